// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one line-wide RAM port between icache fills and the LSU.
// One request in flight at a time; results come back with a one-cycle done pulse.
module mem_arbiter #(
  parameter int ADDR_WIDTH  = 17,
  parameter int WORD_WIDTH  = 32,
  parameter int BLOCK_WIDTH = 2,
  parameter int RAM_WIDTH   = WORD_WIDTH << BLOCK_WIDTH
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      rdy,
  input  logic                      icache_req,
  input  logic [ADDR_WIDTH-1:0]     icache_addr,
  output logic                      icache_done,
  output logic [RAM_WIDTH-1:0]      icache_rdata,
  input  logic                      lsu_req,
  input  logic                      lsu_we,
  input  logic [ADDR_WIDTH-1:0]     lsu_addr,
  input  logic [WORD_WIDTH-1:0]     lsu_wdata,
  input  logic [WORD_WIDTH/8-1:0]   lsu_be,
  output logic                      lsu_done,
  output logic [WORD_WIDTH-1:0]     lsu_rdata,
  output logic [ADDR_WIDTH-1:0]     ram_addr,
  output logic [RAM_WIDTH-1:0]      ram_din,
  output logic [RAM_WIDTH/8-1:0]    ram_we,
  input  logic [RAM_WIDTH-1:0]      ram_dout,
  output logic                      busy
);

  localparam int WORDS    = 1 << BLOCK_WIDTH;
  localparam int BE_W     = WORD_WIDTH / 8;
  localparam int RAM_BE_W = RAM_WIDTH / 8;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  state_t                  r_state;
  state_t                  w_next;
  logic                    r_last_lsu;
  logic                    r_gnt_lsu;
  logic                    r_we;
  logic [BLOCK_WIDTH-1:0]  r_off;
  logic [BE_W-1:0]         r_be;
  logic [ADDR_WIDTH-1:0]   r_ram_addr;
  logic [RAM_WIDTH-1:0]    r_ram_din;
  logic [RAM_WIDTH-1:0]    r_icache_rdata;
  logic [WORD_WIDTH-1:0]   r_lsu_rdata;

  logic                    w_any_req;
  logic                    w_grant_lsu;
  logic                    w_accept;
  logic [ADDR_WIDTH-1:0]   w_sel_addr;
  logic [RAM_BE_W-1:0]     w_we_line;
  logic                    w_unused;

  assign w_any_req   = icache_req | lsu_req;
  // On a tie the requester not served last time wins; pointer starts at icache.
  assign w_grant_lsu = lsu_req & (~icache_req | ~r_last_lsu);
  assign w_accept    = rdy & (r_state == S_IDLE) & w_any_req;
  assign w_sel_addr  = w_grant_lsu ? lsu_addr : icache_addr;
  assign w_unused    = ^w_sel_addr[BLOCK_WIDTH-1:0];

  assign w_we_line = {{(RAM_BE_W-BE_W){1'b0}}, r_be} << (BE_W * int'(r_off));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else if (rdy) begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_any_req) w_next = S_ISSUE;
      S_ISSUE: w_next = r_we ? S_RESP : S_WAIT;
      S_WAIT:  w_next = S_RESP;
      S_RESP:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    icache_done = 1'b0;
    lsu_done    = 1'b0;
    busy        = 1'b1;
    ram_we      = '0;
    case (r_state)
      S_IDLE:  busy = 1'b0;
      S_ISSUE: if (r_we && rdy) ram_we = w_we_line;
      S_RESP: begin
        if (r_gnt_lsu) lsu_done    = 1'b1;
        else           icache_done = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_last_lsu <= 1'b0;
      r_gnt_lsu  <= 1'b0;
      r_we       <= 1'b0;
      r_off      <= '0;
      r_be       <= '0;
      r_ram_addr <= '0;
      r_ram_din  <= '0;
    end else if (w_accept) begin
      r_gnt_lsu  <= w_grant_lsu;
      r_last_lsu <= w_grant_lsu;
      r_we       <= w_grant_lsu & lsu_we;
      r_off      <= lsu_addr[BLOCK_WIDTH-1:0];
      r_be       <= lsu_be;
      r_ram_addr <= {w_sel_addr[ADDR_WIDTH-1:BLOCK_WIDTH], {BLOCK_WIDTH{1'b0}}};
      r_ram_din  <= {WORDS{lsu_wdata}};
    end
  end

  // RAM data is valid in WAIT; pick the whole line or a single word.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_icache_rdata <= '0;
      r_lsu_rdata    <= '0;
    end else if (rdy && r_state == S_WAIT) begin
      if (r_gnt_lsu) r_lsu_rdata    <= ram_dout[int'(r_off)*WORD_WIDTH +: WORD_WIDTH];
      else           r_icache_rdata <= ram_dout;
    end
  end

  assign ram_addr     = r_ram_addr;
  assign ram_din      = r_ram_din;
  assign icache_rdata = r_icache_rdata;
  assign lsu_rdata    = r_lsu_rdata;

endmodule
